shift_in: RTL and testbench

Serial-to-parallel receiver for the one-bit-per-clock framed link driven by the byte shifter. It watches the line for the 10-bit frame: idle-low line, a high start bit, 8 data bits LSB first, a low stop bit. It assembles the byte and presents it to the microprocessor with a valid/ack handshake. It sits at the receive end of the same wire, in the same clock domain as the transmitter unless the synchronizer is compiled in.

---
 rtl/shift_in.sv | 137 +++++++++++++
 tb/tb_shift_in.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_in.sv
// shift_in: serial-to-parallel receiver for the 1-bit-per-clock framed link.
// Frame: high start bit, WIDTH data bits LSB first, low stop bit; line idles low.
// The received byte is handed to the microprocessor over a valid/ack handshake.
// Optional build macro SHIFT_IN_SYNC_EN: routes the serial line through a
// 2-flop synchronizer (reset to 0) for a transmitter in another clock domain.
// That adds two cycles of latency from the pin to every output.
module shift_in #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic             ack,
   output logic [WIDTH-1:0] byteOut,
   output logic             valid,
   output logic             busy,
   output logic             frameErr,
   output logic             overrun
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_STOP = 2'd2;

   logic [1:0]       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [WIDTH-1:0] byte_nxt;
   logic             valid_nxt;
   logic             busy_nxt;
   logic             ferr_nxt;
   logic             ovr_nxt;
   logic             ack_q;
   logic             ack_rise;
   logic             line;

`ifdef SHIFT_IN_SYNC_EN
   logic sync_q1, sync_q2;

   // Two-flop synchronizer on the serial line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= in;
         sync_q2 <= sync_q1;
      end
   end

   assign line = sync_q2;
`else
   assign line = in;
`endif

   // Rising edge of ack, against the previous-cycle sample
   assign ack_rise = ack & ~ack_q;

   // Next-state and next-output logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shreg_nxt = shreg;
      byte_nxt  = byteOut;
      valid_nxt = valid;
      ferr_nxt  = frameErr;
      ovr_nxt   = overrun;

      // Ack first, so a frame completing in the same cycle sees the slot free
      if (ack_rise) begin
         valid_nxt = 1'b0;
         ferr_nxt  = 1'b0;
         ovr_nxt   = 1'b0;
      end

      case (state)
         S_IDLE: begin
            if (line) begin
               state_nxt = S_DATA;
               cnt_nxt   = '0;
            end
         end
         S_DATA: begin
            shreg_nxt = {line, shreg[WIDTH-1:1]};
            if (cnt == CNT_W'(WIDTH - 1)) begin
               state_nxt = S_STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_STOP: begin
            state_nxt = S_IDLE;
            if (line) begin
               ferr_nxt = 1'b1;
            end else if (valid_nxt) begin
               ovr_nxt = 1'b1;
            end else begin
               byte_nxt  = shreg;
               valid_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         shreg    <= '0;
         byteOut  <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         frameErr <= 1'b0;
         overrun  <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         shreg    <= shreg_nxt;
         byteOut  <= byte_nxt;
         valid    <= valid_nxt;
         busy     <= busy_nxt;
         frameErr <= ferr_nxt;
         overrun  <= ovr_nxt;
         ack_q    <= ack;
      end
   end

endmodule

// File: tb/tb_shift_in.sv
// tb_shift_in: directed bench for shift_in with a scoreboard of expected frame results.
module tb_shift_in;

   typedef struct {
      logic [7:0] byte_val;
      logic       valid;
      logic       ferr;
      logic       ovr;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       line_in;
   logic       ack;
   logic [7:0] byte_out;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       overrun;

   int total;
   int passed;
   int failed;

   exp_t       sb_q[$];
   logic [7:0] m_byte;
   logic       m_valid;
   logic       m_ferr;
   logic       m_ovr;

   shift_in #(.WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .in      (line_in),
      .ack     (ack),
      .byteOut (byte_out),
      .valid   (valid),
      .busy    (busy),
      .frameErr(frame_err),
      .overrun (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_byte  = 8'h00;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_ack();
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   // Expected state once a frame completes; pushed when the frame is driven
   task automatic model_frame(input logic [7:0] d, input logic bad, input logic ack_edge);
      exp_t e;
      if (ack_edge) model_ack();
      if (bad) m_ferr = 1'b1;
      else if (m_valid) m_ovr = 1'b1;
      else begin
         m_byte  = d;
         m_valid = 1'b1;
      end
      e.byte_val = m_byte;
      e.valid    = m_valid;
      e.ferr     = m_ferr;
      e.ovr      = m_ovr;
      sb_q.push_back(e);
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".byte"},  32'(byte_out),  32'(m_byte));
      check({tag, ".valid"}, 32'(valid),     32'(m_valid));
      check({tag, ".ferr"},  32'(frame_err), 32'(m_ferr));
      check({tag, ".ovr"},   32'(overrun),   32'(m_ovr));
   endtask

   // Drives one frame starting in the current cycle; returns in cycle T+10
   task automatic send_frame(input string tag, input logic [7:0] d, input logic bad,
                             input logic ack_stop);
      exp_t e;
      model_frame(d, bad, ack_stop);
      line_in = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         check({tag, ".busy_data"}, 32'(busy), 32'(1));
         line_in = d[i];
         tick();
      end
      check({tag, ".busy_last"}, 32'(busy), 32'(1));
      line_in = bad;
      if (ack_stop) ack = 1'b1;
      tick();
      line_in = 1'b0;
      check({tag, ".busy_end"}, 32'(busy), 32'(0));
      total++;
      assert (sb_q.size() > 0) passed++;
      else begin
         failed++;
         $error("FAIL %s.sb: observed empty scoreboard expected entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, ".sb_byte"},  32'(byte_out),  32'(e.byte_val));
         check({tag, ".sb_valid"}, 32'(valid),     32'(e.valid));
         check({tag, ".sb_ferr"},  32'(frame_err), 32'(e.ferr));
         check({tag, ".sb_ovr"},   32'(overrun),   32'(e.ovr));
      end
   endtask

   initial begin
      logic [7:0] d99;
      total   = 0;
      passed  = 0;
      failed  = 0;
      rst     = 1'b0;
      line_in = 1'b0;
      ack     = 1'b0;
      model_reset();

      // Reset values
      #2;
      check_outputs("reset");
      check("reset.busy", 32'(busy), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();

      // Single good frame
      send_frame("a5", 8'hA5, 1'b0, 1'b0);
      tick();

      // Handshake: ack held high while the next byte arrives
      ack = 1'b1;
      tick();
      model_ack();
      check("hs.valid_fall", 32'(valid), 32'(0));
      send_frame("3c", 8'h3C, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) tick();
      check_outputs("hs.held");
      ack = 1'b0;
      tick();
      check("hs.after_fall", 32'(valid), 32'(1));
      ack = 1'b1;
      tick();
      model_ack();
      check_outputs("hs.second_edge");
      ack = 1'b0;
      tick();

      // Back-to-back frames with no ack -> overrun
      send_frame("b2b_01", 8'h01, 1'b0, 1'b0);
      send_frame("b2b_ff", 8'hFF, 1'b0, 1'b0);

      // Ack edge on the completion cycle of a new byte
      send_frame("sim_7e", 8'h7E, 1'b0, 1'b1);
      ack = 1'b0;
      tick();

      // Framing error
      send_frame("ferr_55", 8'h55, 1'b1, 1'b0);
      tick();
      check("ferr.idle", 32'(busy), 32'(0));
      check_outputs("ferr.hold");

      // Reset during data bit 4
      d99 = 8'h99;
      line_in = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         line_in = d99[i];
         tick();
      end
      line_in = d99[4];
      rst = 1'b0;
      #1;
      model_reset();
      check_outputs("midrst");
      check("midrst.busy", 32'(busy), 32'(0));
      tick();
      rst = 1'b1;
      line_in = 1'b0;
      tick();
      check("midrst.idle", 32'(busy), 32'(0));
      send_frame("post_42", 8'h42, 1'b0, 1'b0);
      tick();
      check_outputs("final");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
